// File: rtl/alu_pkg.sv
// Shared opcode and width constants for the ALU / counter / decoder utility block.
package alu_pkg;

   localparam int ALU_W = 4;
   localparam int CNT_W = 3;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_NOT = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_EQ  = 3'b111;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU with zero, signed-overflow and carry flags.
module alu4_core
   import alu_pkg::*;
(
   input  logic [2:0]       fnselec_i,
   input  logic [ALU_W-1:0] a_i,
   input  logic [ALU_W-1:0] b_i,
   output logic [ALU_W-1:0] res_o,
   output logic             zero_o,
   output logic             overflow_o,
   output logic             carry_o
);

   logic [ALU_W:0] sum_add;
   logic [ALU_W:0] sum_sub;
   logic           ovf_add;
   logic           ovf_sub;
   logic           lt;

   // Subtraction is A + ~B + 1, so carry-out high means "no borrow".
   assign sum_add = {1'b0, a_i} + {1'b0, b_i};
   assign sum_sub = {1'b0, a_i} + {1'b0, ~b_i} + {{ALU_W{1'b0}}, 1'b1};
   assign ovf_add = (a_i[ALU_W-1] == b_i[ALU_W-1]) && (sum_add[ALU_W-1] != a_i[ALU_W-1]);
   assign ovf_sub = (a_i[ALU_W-1] != b_i[ALU_W-1]) && (sum_sub[ALU_W-1] != a_i[ALU_W-1]);
   assign lt      = sum_sub[ALU_W-1] ^ ovf_sub;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      res_o      = '0;
      overflow_o = 1'b0;
      carry_o    = 1'b0;
      case (fnselec_i)
         ALU_ADD: begin
            res_o      = sum_add[ALU_W-1:0];
            overflow_o = ovf_add;
            carry_o    = sum_add[ALU_W];
         end
         ALU_SUB: begin
            res_o      = sum_sub[ALU_W-1:0];
            overflow_o = ovf_sub;
            carry_o    = sum_sub[ALU_W];
         end
         ALU_NOT: res_o = ~a_i;
         ALU_AND: res_o = a_i & b_i;
         ALU_OR:  res_o = a_i | b_i;
         ALU_XOR: res_o = a_i ^ b_i;
         ALU_SLT: res_o = {{(ALU_W-1){1'b0}}, lt};
         ALU_EQ:  res_o = {{(ALU_W-1){1'b0}}, (a_i == b_i)};
         default: res_o = '0;
      endcase
   end

   assign zero_o = (res_o == '0);

endmodule

// File: rtl/alu_count_decode.sv
// ALU, wrapping 3-bit down-counter and 3-to-8 decoder on one clock.
// Define ALU_OUT_REG_EN to register the ALU outputs (1-cycle latency, reset to 0).
module alu_count_decode
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       alu_fnselec,
   input  logic [ALU_W-1:0] alu_a,
   input  logic [ALU_W-1:0] alu_b,
   output logic [ALU_W-1:0] alu_res,
   output logic             alu_zero,
   output logic             alu_overflow,
   output logic             alu_carry,
   input  logic             counter_en,
   output logic [CNT_W-1:0] dec_counter_out,
   input  logic [2:0]       x,
   input  logic             en,
   output logic [7:0]       y_dec
);

   logic [ALU_W-1:0] core_res;
   logic             core_zero;
   logic             core_overflow;
   logic             core_carry;

   alu4_core u_alu4_core (
      .fnselec_i  (alu_fnselec),
      .a_i        (alu_a),
      .b_i        (alu_b),
      .res_o      (core_res),
      .zero_o     (core_zero),
      .overflow_o (core_overflow),
      .carry_o    (core_carry)
   );

`ifdef ALU_OUT_REG_EN
   logic [ALU_W-1:0] alu_res_q;
   logic             alu_zero_q;
   logic             alu_overflow_q;
   logic             alu_carry_q;

   // Zero is forced low in reset rather than tracking the cleared result.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_res_q      <= '0;
         alu_zero_q     <= 1'b0;
         alu_overflow_q <= 1'b0;
         alu_carry_q    <= 1'b0;
      end else begin
         alu_res_q      <= core_res;
         alu_zero_q     <= core_zero;
         alu_overflow_q <= core_overflow;
         alu_carry_q    <= core_carry;
      end
   end

   assign alu_res      = alu_res_q;
   assign alu_zero     = alu_zero_q;
   assign alu_overflow = alu_overflow_q;
   assign alu_carry    = alu_carry_q;
`else
   assign alu_res      = core_res;
   assign alu_zero     = core_zero;
   assign alu_overflow = core_overflow;
   assign alu_carry    = core_carry;
`endif

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Natural modulo-8 arithmetic gives the 0 -> 7 wrap.
   assign cnt_d = counter_en ? (cnt_q - {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign dec_counter_out = cnt_q;

   always_comb begin
      y_dec = 8'h00;
      if (en) y_dec = 8'h01 << x;
   end

endmodule

// File: tb/tb_alu_count_decode.sv
// Directed, table-driven bench for alu_count_decode (handles either ALU_OUT_REG_EN build).
module tb_alu_count_decode;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] alu_fnselec;
   logic [3:0] alu_a, alu_b, alu_res;
   logic       alu_zero, alu_overflow, alu_carry;
   logic       counter_en;
   logic [2:0] dec_counter_out;
   logic [2:0] x;
   logic       en;
   logic [7:0] y_dec;

   int n_checks = 0;
   int n_fail   = 0;

   alu_count_decode dut (
      .clk             (clk),
      .rst             (rst),
      .alu_fnselec     (alu_fnselec),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_res         (alu_res),
      .alu_zero        (alu_zero),
      .alu_overflow    (alu_overflow),
      .alu_carry       (alu_carry),
      .counter_en      (counter_en),
      .dec_counter_out (dec_counter_out),
      .x               (x),
      .en              (en),
      .y_dec           (y_dec)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] res;
      logic       zero;
      logic       ovf;
      logic       carry;
   } alu_vec_t;

   alu_vec_t vecs[17];

   // Drive ALU inputs mid-low-phase and return when the result is observable.
   task automatic apply_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      alu_fnselec = op;
      alu_a       = a;
      alu_b       = b;
`ifdef ALU_OUT_REG_EN
      @(posedge clk);
`endif
      #1;
   endtask

   logic [2:0] cnt_seq[9];

   initial begin
      rst = 1'b1; counter_en = 1'b0; en = 1'b0; x = 3'd0;
      alu_fnselec = ALU_ADD; alu_a = 4'h7; alu_b = 4'h1;

      vecs[0]  = '{ALU_ADD, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{ALU_ADD, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{ALU_SUB, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{ALU_SUB, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1};
      vecs[4]  = '{ALU_SUB, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{ALU_NOT, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{ALU_NOT, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{ALU_AND, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{ALU_OR,  4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{ALU_XOR, 4'b0110, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{ALU_XOR, 4'b1001, 4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{ALU_SLT, 4'b1110, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{ALU_SLT, 4'b0001, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{ALU_SLT, 4'b1000, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{ALU_EQ,  4'b1010, 4'b1010, 4'b0001, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{ALU_EQ,  4'b1010, 4'b1011, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[16] = '{ALU_AND, 4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0};

      cnt_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

      // Reset state.
      @(posedge clk); #1;
      check("rst_counter", 32'(dec_counter_out), 32'd0);
`ifdef ALU_OUT_REG_EN
      check("rst_alu_res",   32'(alu_res),      32'd0);
      check("rst_alu_zero",  32'(alu_zero),     32'd0);
      check("rst_alu_ovf",   32'(alu_overflow), 32'd0);
      check("rst_alu_carry", 32'(alu_carry),    32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         apply_alu(vecs[i].op, vecs[i].a, vecs[i].b);
         check($sformatf("alu_res[%0d]", i),   32'(alu_res),      32'(vecs[i].res));
         check($sformatf("alu_zero[%0d]", i),  32'(alu_zero),     32'(vecs[i].zero));
         check($sformatf("alu_ovf[%0d]", i),   32'(alu_overflow), 32'(vecs[i].ovf));
         check($sformatf("alu_carry[%0d]", i), 32'(alu_carry),    32'(vecs[i].carry));
      end

`ifdef ALU_OUT_REG_EN
      // Result must not appear before the capturing edge.
      @(negedge clk);
      alu_fnselec = ALU_ADD; alu_a = 4'b0010; alu_b = 4'b0011;
      #1;
      check("reg_before_edge", 32'(alu_res), 32'(4'b1111));
      @(posedge clk); #1;
      check("reg_after_edge", 32'(alu_res), 32'(4'b0101));
`endif

      // Decoder: enabled walk, then disabled.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] exp_y;
         exp_y = 8'h00;
         exp_y[i] = 1'b1;
         en = 1'b1; x = 3'(i); #1;
         check($sformatf("dec_en_x%0d", i), 32'(y_dec), 32'(exp_y));
      end
      for (int i = 0; i < 8; i++) begin
         en = 1'b0; x = 3'(i); #1;
         check($sformatf("dec_dis_x%0d", i), 32'(y_dec), 32'h00);
      end

      // Counter: 9 enabled edges from 0, wrapping.
      @(negedge clk);
      counter_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         check($sformatf("cnt_step%0d", i), 32'(dec_counter_out), 32'(cnt_seq[i]));
      end
      @(negedge clk);
      counter_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check($sformatf("cnt_hold%0d", i), 32'(dec_counter_out), 32'd7);
      end

      // Reset wins over enable; first edge after release gives 7.
      @(negedge clk);
      rst = 1'b1; counter_en = 1'b1;
      @(posedge clk); #1;
      check("cnt_rst_priority", 32'(dec_counter_out), 32'd0);
`ifdef ALU_OUT_REG_EN
      check("reg_rst_res",  32'(alu_res),  32'd0);
      check("reg_rst_zero", 32'(alu_zero), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("cnt_after_release", 32'(dec_counter_out), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
